alu_initiator: RTL and testbench

ALU_INITIATOR -- requirements
Module: alu_initiator

---
 rtl/alu_initiator_pkg.sv | 35 +++
 rtl/alu_initiator_cmd_fifo.sv | 83 ++++++++
 rtl/alu_initiator.sv | 172 +++++++++++++++++
 tb/tb_alu_initiator.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_initiator_pkg.sv
// Shared types for the ALU initiator: FSM state encoding, op-code constants
// and the packed command record carried through the command FIFO.
package alu_initiator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Codes above XOR select the arithmetic operations of the attached ALU.
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;

    localparam int CMD_W = 19;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] x;
        logic [7:0] y;
    } cmd_t;

    function automatic cmd_t pack_cmd(input logic [7:0] x, input logic [7:0] y,
                                      input logic [2:0] op);
        cmd_t c;
        c.op = op;
        c.x  = x;
        c.y  = y;
        return c;
    endfunction

endpackage

// File: rtl/alu_initiator_cmd_fifo.sv
// Command FIFO for the ALU initiator. Registered ready flag, no read bypass:
// an entry pushed on one edge can be popped on the following edge at the earliest.
module alu_cmd_fifo
    import alu_initiator_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             empty_next,
    output logic             ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push_s, do_pop_s;

    assign do_push_s = push & ready_q;
    assign do_pop_s  = pop & (count_q != {(AW + 1){1'b0}});

    // Pointer and occupancy update; pointers wrap naturally at a power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW - 1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW - 1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        ready_d = (count_d != FULL_LVL);
    end

    // Control state registers; ready stays low while reset is asserted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data   = mem_q[rd_ptr_q];
    assign empty      = (count_q == {(AW + 1){1'b0}});
    assign empty_next = (count_d == {(AW + 1){1'b0}});
    assign ready      = ready_q;

endmodule

// File: rtl/alu_initiator.sv
// ALU initiator: queues operand commands, issues them one at a time to a
// handshake-less ALU, and returns results (or a timeout marker) in order.
module alu_initiator
    import alu_initiator_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_x,
    input  logic [7:0]  cmd_y,
    input  logic [2:0]  cmd_op,
    output logic [7:0]  alu_x,
    output logic [7:0]  alu_y,
    output logic [2:0]  alu_op,
    output logic        alu_begin,
    input  logic        alu_end,
    input  logic [15:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [2:0]  rsp_op,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    cmd_t        cmd_in_s, head_s;
    logic        push_s, pop_s;
    logic        fifo_empty_s, fifo_empty_next_s, fifo_ready_s;
    logic [7:0]  cnt_inc_s;

    state_e      state_q, state_d;
    cmd_t        opnd_q, opnd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        alu_begin_q, alu_begin_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic [2:0]  rsp_op_q, rsp_op_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic        busy_q, busy_d;

    assign cmd_in_s = pack_cmd(cmd_x, cmd_y, cmd_op);
    assign push_s   = cmd_valid & fifo_ready_s;

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (push_s),
        .push_data  (cmd_in_s),
        .pop        (pop_s),
        .pop_data   (head_s),
        .empty      (fifo_empty_s),
        .empty_next (fifo_empty_next_s),
        .ready      (fifo_ready_s)
    );

    // Next-state logic; every output is computed here and registered below.
    always_comb begin
        state_d       = state_q;
        opnd_d        = opnd_q;
        cnt_d         = cnt_q;
        alu_begin_d   = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_op_d      = rsp_op_q;
        rsp_timeout_d = rsp_timeout_q;
        pop_s         = 1'b0;
        cnt_inc_s     = cnt_q + 8'd1;

        case (state_q)
            ST_IDLE: begin
                // A still-high alu_end belongs to the previous command; never issue over it.
                if (!fifo_empty_s && !alu_end) begin
                    pop_s       = 1'b1;
                    opnd_d      = head_s;
                    alu_begin_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_end) begin
                    rsp_data_d    = alu_out;
                    rsp_timeout_d = 1'b0;
                    rsp_op_d      = opnd_q.op;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    cnt_d         = cnt_inc_s;
                    rsp_data_d    = 16'h0000;
                    rsp_timeout_d = 1'b1;
                    rsp_op_d      = opnd_q.op;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d   = cnt_inc_s;
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_DRAIN;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (!alu_end) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) || !fifo_empty_next_s;
    end

    // FSM and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            opnd_q        <= pack_cmd(8'h00, 8'h00, 3'b000);
            cnt_q         <= 8'd0;
            alu_begin_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 16'h0000;
            rsp_op_q      <= 3'b000;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            opnd_q        <= opnd_d;
            cnt_q         <= cnt_d;
            alu_begin_q   <= alu_begin_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_op_q      <= rsp_op_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign cmd_ready   = fifo_ready_s;
    assign alu_x       = opnd_q.x;
    assign alu_y       = opnd_q.y;
    assign alu_op      = opnd_q.op;
    assign alu_begin   = alu_begin_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_initiator.sv
// Self-checking bench for alu_initiator: table of single-command vectors plus
// directed sequences for timeout, back-pressure, FIFO full, alu_end hold and reset.
`timescale 1ns/1ps
module tb_alu_initiator;
    import alu_initiator_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 10;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_x, cmd_y;
    logic [2:0]  cmd_op;
    logic [7:0]  alu_x, alu_y;
    logic [2:0]  alu_op;
    logic        alu_begin, alu_end;
    logic [15:0] alu_out;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_op;
    logic        rsp_timeout, busy;

    always #5 clk = ~clk;

    alu_initiator #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_op(cmd_op),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_begin(alu_begin), .alu_end(alu_end), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_timeout(rsp_timeout),
        .busy(busy)
    );

    // ALU stand-in: result after alu_lat cycles, alu_end held for alu_hold cycles.
    int          alu_lat   = 3;
    int          alu_hold  = 1;
    bit          alu_dead  = 1'b0;
    bit          force_end = 1'b0;
    logic        alu_end_m = 1'b0;
    logic [15:0] alu_out_m = 16'h0000;
    logic [15:0] m_res     = 16'h0000;
    int          m_cnt     = 0;
    int          m_hold    = 0;

    assign alu_end = alu_end_m | force_end;
    assign alu_out = alu_out_m;

    function automatic logic [15:0] alu_fn(input logic [7:0] x, input logic [7:0] y,
                                           input logic [2:0] op);
        case (op)
            OP_AND:  return {8'h00, x & y};
            OP_OR:   return {8'h00, x | y};
            OP_XOR:  return {8'h00, x ^ y};
            3'd4:    return {8'h00, x} - {8'h00, y};
            3'd5:    return {8'h00, x} * {8'h00, y};
            default: return {8'h00, x} + {8'h00, y};
        endcase
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            alu_end_m <= 1'b0;
            m_cnt     <= 0;
            m_hold    <= 0;
        end else if (alu_begin && !alu_dead) begin
            m_cnt <= alu_lat;
            m_res <= alu_fn(alu_x, alu_y, alu_op);
        end else if (m_cnt > 0) begin
            if (m_cnt == 1) begin
                alu_end_m <= 1'b1;
                alu_out_m <= m_res;
                m_hold    <= alu_hold;
            end
            m_cnt <= m_cnt - 1;
        end else if (m_hold > 0) begin
            if (m_hold == 1) alu_end_m <= 1'b0;
            m_hold <= m_hold - 1;
        end
    end

    // Monitor: counts begin pulses, gap between them, and begins issued over a high alu_end.
    int   cyc = 0, begin_cnt = 0, viol = 0, last_begin = 0, gap = 0;
    logic end_prev = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        end_prev <= alu_end;
        if (alu_begin) begin
            begin_cnt  <= begin_cnt + 1;
            gap        <= cyc - last_begin;
            last_begin <= cyc;
            if (end_prev) viol <= viol + 1;
        end
    end

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
        bit ok;
        ok = 1'b0;
        cmd_x = x; cmd_y = y; cmd_op = op; cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ok = cmd_ready;
            step();
            if (ok) break;
        end
        cmd_valid = 1'b0;
        chk("push_accepted", ok, 1);
    endtask

    task automatic wait_rsp(output int n, output logic prev_end);
        n = 0;
        prev_end = alu_end;
        while (!rsp_valid && n < 100) begin
            prev_end = alu_end;
            step();
            n++;
        end
        chk("rsp_valid_seen", rsp_valid, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk("return_idle", busy, 0);
    endtask

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [2:0]  op;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] bexp [5];
    logic        pe;
    int          n, b0;
    bit          flag;

    initial begin
        vecs[0] = '{8'h0C, 8'h05, 3'b000, 16'h0004};
        vecs[1] = '{8'hF0, 8'h0F, 3'b001, 16'h00FF};
        vecs[2] = '{8'hAA, 8'hFF, 3'b010, 16'h0055};
        vecs[3] = '{8'hFF, 8'h01, 3'b011, 16'h0100};
        vecs[4] = '{8'h10, 8'h20, 3'b100, 16'hFFF0};
        vecs[5] = '{8'hFF, 8'hFF, 3'b101, 16'hFE01};
        bexp = '{16'h0001, 16'h002F, 16'h002C, 16'h0033, 16'h0016};

        resetn = 1'b0; cmd_valid = 1'b0; cmd_x = 8'h00; cmd_y = 8'h00;
        cmd_op = 3'b000; rsp_ready = 1'b0;
        repeat (3) step();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_alu_begin", alu_begin, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_op", rsp_op, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_alu_operands", {alu_x, alu_y, alu_op}, 0);
        chk("rst_busy", busy, 0);
        resetn = 1'b1;
        step();
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Table of single commands, response accepted immediately.
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b0 = begin_cnt;
            push(vecs[i].x, vecs[i].y, vecs[i].op);
            if (i == 0) begin
                chk("no_bypass_begin", alu_begin, 0);
                step();
                chk("begin_after_push", alu_begin, 1);
                step();
                chk("begin_one_cycle", alu_begin, 0);
            end
            wait_rsp(n, pe);
            chk("end_to_rsp_1cyc", pe, 1);
            chk("vec_rsp_data", rsp_data, vecs[i].exp);
            chk("vec_rsp_op", rsp_op, vecs[i].op);
            chk("vec_rsp_timeout", rsp_timeout, 0);
            step();
            chk("vec_rsp_drop", rsp_valid, 0);
            wait_idle();
            chk("vec_begin_pulses", begin_cnt - b0, 1);
        end

        // Timeout, then 20 cycles of back-pressure with a command queued.
        alu_dead = 1'b1; rsp_ready = 1'b0;
        push(8'h12, 8'h34, 3'b011);
        n = 0;
        while (!alu_begin && n < 20) begin step(); n++; end
        chk("to_begin_seen", alu_begin, 1);
        n = 0;
        while (!rsp_valid && n < 40) begin step(); n++; end
        chk("timeout_latency", n, 11);
        chk("timeout_flag", rsp_timeout, 1);
        chk("timeout_data", rsp_data, 0);
        chk("timeout_op", rsp_op, 3);
        push(8'h03, 8'h04, 3'b011);
        b0 = begin_cnt;
        flag = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!rsp_valid || rsp_data !== 16'h0000 || rsp_timeout !== 1'b1 || rsp_op !== 3'd3)
                flag = 1'b0;
            step();
        end
        chk("stall_payload_stable", flag, 1);
        chk("stall_no_begin", begin_cnt - b0, 0);
        alu_dead = 1'b0; rsp_ready = 1'b1;
        step();
        chk("stall_rsp_drop", rsp_valid, 0);
        wait_rsp(n, pe);
        chk("after_stall_data", rsp_data, 16'h0007);
        chk("after_stall_timeout", rsp_timeout, 0);
        step();
        wait_idle();

        // FIFO full while alu_end is held high, then five ordered responses.
        force_end = 1'b1;
        step();
        b0 = begin_cnt;
        for (int i = 0; i < 4; i++) push(8'h21 + 8'(i), 8'h0F, 3'(i));
        chk("full_ready_low", cmd_ready, 0);
        chk("full_no_begin", begin_cnt - b0, 0);
        chk("full_busy", busy, 1);
        cmd_x = 8'h25; cmd_y = 8'h0F; cmd_op = 3'd4; cmd_valid = 1'b1;
        flag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (cmd_ready) flag = 1'b0;
            step();
        end
        chk("full_holds", flag, 1);
        force_end = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            flag = cmd_ready;
            step();
            if (flag) break;
        end
        cmd_valid = 1'b0;
        chk("fifth_accepted", flag, 1);
        chk("fifth_after_pop", begin_cnt - b0, 1);
        for (int i = 0; i < 5; i++) begin
            wait_rsp(n, pe);
            chk("order_op", rsp_op, i);
            chk("order_data", rsp_data, bexp[i]);
            step();
        end
        wait_idle();
        chk("order_begins", begin_cnt - b0, 5);

        // alu_end lingers after completion: next issue waits for it to fall.
        alu_hold = 6;
        push(8'h05, 8'h06, 3'b000);
        push(8'h07, 8'h01, 3'b011);
        wait_rsp(n, pe);
        chk("hold_rsp0", rsp_data, 16'h0004);
        step();
        wait_rsp(n, pe);
        chk("hold_rsp1", rsp_data, 16'h0008);
        step();
        wait_idle();
        chk("hold_begin_gap", gap, 12);
        chk("no_begin_over_end", viol, 0);
        alu_hold = 1;

        // Reset in the middle of WAIT with another command queued.
        alu_dead = 1'b1; rsp_ready = 1'b0;
        b0 = begin_cnt;
        push(8'h11, 8'h22, 3'b001);
        push(8'h33, 8'h44, 3'b010);
        n = 0;
        while (begin_cnt == b0 && n < 20) begin step(); n++; end
        chk("mid_begin_seen", begin_cnt - b0, 1);
        step();
        resetn = 1'b0;
        step();
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_alu_begin", alu_begin, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        chk("mid_rst_rsp_op", rsp_op, 0);
        chk("mid_rst_rsp_timeout", rsp_timeout, 0);
        chk("mid_rst_operands", {alu_x, alu_y, alu_op}, 0);
        chk("mid_rst_busy", busy, 0);
        resetn = 1'b1; alu_dead = 1'b0; rsp_ready = 1'b1;
        b0 = begin_cnt;
        flag = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (rsp_valid || busy) flag = 1'b1;
            step();
        end
        chk("no_stale_rsp", flag, 0);
        chk("fifo_flushed", begin_cnt - b0, 0);
        chk("mid_rst_ready_back", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
